// File: rtl/tcounter_nbit.sv
// Up/down modulo-(MAX_COUNT+1) counter built from a T flip-flop toggle chain with load, cascade tc and wrap pulse.
// Define TCOUNTER_SAT_EN to saturate at 0/MAX_COUNT instead of wrapping (o_wrap then tied low).
module tcounter_nbit #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}}
) (
  input  logic             i_clk,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic             i_up,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_Q,
  output logic             o_tc,
  output logic             o_wrap
);

  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] borrow;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] bound_val;
  logic [WIDTH-1:0] q_nxt;
  logic             at_top;
  logic             at_bot;
  logic             bound;

  // carry[i]: all lower bits are 1; borrow[i]: all lower bits are 0
  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;

  genvar i;
  generate
    for (i = 1; i < WIDTH; i++) begin : g_chain
      assign carry[i]  = carry[i-1] & o_Q[i-1];
      assign borrow[i] = borrow[i-1] & ~o_Q[i-1];
    end
    for (i = 0; i < WIDTH; i++) begin : g_toggle
      assign t[i] = i_enable & (i_up ? carry[i] : borrow[i]);
    end
  endgenerate

  assign at_top   = (o_Q == MAX_COUNT);
  assign at_bot   = (o_Q == '0);
  assign bound    = i_enable & (i_up ? at_top : at_bot);
  assign o_tc     = bound;
  assign load_val = (i_data > MAX_COUNT) ? MAX_COUNT : i_data;

  // At the modulus boundary the toggle chain is overridden by the wrap (or hold) value
`ifdef TCOUNTER_SAT_EN
  assign bound_val = o_Q;
`else
  assign bound_val = i_up ? '0 : MAX_COUNT;
`endif

  always_comb begin
    q_nxt = o_Q ^ t;
    if (i_load) begin
      q_nxt = load_val;
    end else if (bound) begin
      q_nxt = bound_val;
    end
  end

  always_ff @(posedge i_clk or posedge i_clear) begin
    if (i_clear) begin
      o_Q <= '0;
    end else begin
      o_Q <= q_nxt;
    end
  end

`ifdef TCOUNTER_SAT_EN
  assign o_wrap = 1'b0;
`else
  always_ff @(posedge i_clk or posedge i_clear) begin
    if (i_clear) begin
      o_wrap <= 1'b0;
    end else begin
      o_wrap <= ~i_load & bound;
    end
  end
`endif

endmodule

// File: tb/tb_tcounter_nbit.sv
// Bench for tcounter_nbit: 4-bit mod-10 counter, a two-stage mod-10 cascade and an 8-bit full-width counter.
// An arithmetic model is compared every cycle; directed sequences pin literal values.
module tb_tcounter_nbit;

`ifdef TCOUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clear;
  logic       up;
  logic       load;
  logic       en_a;
  logic       en_c;
  logic       en_b;
  logic [3:0] data;

  logic [3:0] q_a, q_lo, q_hi;
  logic [7:0] q_b;
  logic       tc_a, wr_a, tc_lo, wr_lo, tc_hi, wr_hi, tc_b, wr_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tcounter_nbit #(.WIDTH(4), .MAX_COUNT(4'd9)) u_a (
    .i_clk(clk), .i_clear(clear), .i_enable(en_a), .i_up(up), .i_load(load),
    .i_data(data), .o_Q(q_a), .o_tc(tc_a), .o_wrap(wr_a)
  );

  tcounter_nbit #(.WIDTH(4), .MAX_COUNT(4'd9)) u_lo (
    .i_clk(clk), .i_clear(clear), .i_enable(en_c), .i_up(up), .i_load(load),
    .i_data(data), .o_Q(q_lo), .o_tc(tc_lo), .o_wrap(wr_lo)
  );

  tcounter_nbit #(.WIDTH(4), .MAX_COUNT(4'd9)) u_hi (
    .i_clk(clk), .i_clear(clear), .i_enable(tc_lo), .i_up(up), .i_load(load),
    .i_data(data), .o_Q(q_hi), .o_tc(tc_hi), .o_wrap(wr_hi)
  );

  tcounter_nbit #(.WIDTH(8), .MAX_COUNT(8'd255)) u_b (
    .i_clk(clk), .i_clear(clear), .i_enable(en_b), .i_up(up), .i_load(load),
    .i_data({4'b0000, data}), .o_Q(q_b), .o_tc(tc_b), .o_wrap(wr_b)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int nq(int q, int mx, bit en, bit dir_up, bit ld, int d);
    if (ld) return (d > mx) ? mx : d;
    if (!en) return q;
    if (SAT) begin
      if (dir_up) return (q == mx) ? mx : q + 1;
      return (q == 0) ? 0 : q - 1;
    end
    if (dir_up) return (q + 1) % (mx + 1);
    return (q + mx) % (mx + 1);
  endfunction

  function automatic bit nw(int q, int mx, bit en, bit dir_up, bit ld);
    if (SAT || ld || !en) return 1'b0;
    return dir_up ? (q == mx) : (q == 0);
  endfunction

  function automatic bit tcm(int q, int mx, bit en, bit dir_up);
    return en && (dir_up ? (q == mx) : (q == 0));
  endfunction

  int m_a, m_lo, m_hi, m_b;
  bit w_a, w_lo, w_hi, w_b;
  bit lo_tc_v;

  always @(posedge clk or posedge clear) begin
    if (clear) begin
      m_a = 0; m_lo = 0; m_hi = 0; m_b = 0;
      w_a = 0; w_lo = 0; w_hi = 0; w_b = 0;
    end else begin
      lo_tc_v = tcm(m_lo, 9, en_c, up);
      w_a  = nw(m_a, 9, en_a, up, load);
      m_a  = nq(m_a, 9, en_a, up, load, int'(data));
      w_lo = nw(m_lo, 9, en_c, up, load);
      m_lo = nq(m_lo, 9, en_c, up, load, int'(data));
      w_hi = nw(m_hi, 9, lo_tc_v, up, load);
      m_hi = nq(m_hi, 9, lo_tc_v, up, load, int'(data));
      w_b  = nw(m_b, 255, en_b, up, load);
      m_b  = nq(m_b, 255, en_b, up, load, int'(data));
    end
  end

  always @(negedge clk) begin
    chk("a_q",     32'(q_a),   m_a);
    chk("a_wrap",  32'(wr_a),  32'(w_a));
    chk("a_tc",    32'(tc_a),  32'(tcm(m_a, 9, en_a, up)));
    chk("lo_q",    32'(q_lo),  m_lo);
    chk("lo_wrap", 32'(wr_lo), 32'(w_lo));
    chk("lo_tc",   32'(tc_lo), 32'(tcm(m_lo, 9, en_c, up)));
    chk("hi_q",    32'(q_hi),  m_hi);
    chk("hi_wrap", 32'(wr_hi), 32'(w_hi));
    chk("hi_tc",   32'(tc_hi), 32'(tcm(m_hi, 9, tcm(m_lo, 9, en_c, up), up)));
    chk("b_q",     32'(q_b),   m_b);
    chk("b_wrap",  32'(wr_b),  32'(w_b));
    chk("b_tc",    32'(tc_b),  32'(tcm(m_b, 255, en_b, up)));
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    #2;
    clear = 1'b0;
  endtask

  int up_seq[12];
  int dn_seq[4];
  int nwraps;

  initial begin
    if (SAT) begin
      up_seq = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9, 9};
      dn_seq = '{1, 0, 0, 0};
    end else begin
      up_seq = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
      dn_seq = '{1, 0, 9, 8};
    end
    clear = 1'b1; up = 1'b1; load = 1'b0;
    en_a = 1'b0; en_c = 1'b0; en_b = 1'b0; data = 4'd0;
    repeat (2) tick();
    clear = 1'b0;
    chk("rst_q", 32'(q_a), 0);
    chk("rst_wrap", 32'(wr_a), 0);
    chk("rst_tc", 32'(tc_a), 0);

    // asynchronous clear in the middle of a count
    en_a = 1'b1;
    repeat (6) tick();
    chk("count6", 32'(q_a), 6);
    #1 clear = 1'b1;
    #1;
    chk("clr_async_q", 32'(q_a), 0);
    chk("clr_async_wrap", 32'(wr_a), 0);
    up = 1'b0;
    #1;
    chk("clr_tc_down", 32'(tc_a), 1);
    up = 1'b1;
    clear = 1'b0;
    tick();
    chk("clr_release_q", 32'(q_a), 1);

    // up count across the modulus boundary
    do_clear();
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("up_q", 32'(q_a), up_seq[k]);
      chk("up_wrap", 32'(wr_a), 32'(!SAT && k == 9));
      chk("up_tc", 32'(tc_a), 32'(up_seq[k] == 9));
    end

    // load, count down through zero, then turn around
    load = 1'b1; data = 4'd2;
    tick();
    chk("load2", 32'(q_a), 2);
    load = 1'b0; up = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("dn_q", 32'(q_a), dn_seq[k]);
      chk("dn_wrap", 32'(wr_a), 32'(!SAT && k == 2));
      chk("dn_tc", 32'(tc_a), 32'(dn_seq[k] == 0));
    end
    up = 1'b1;
    tick();
    chk("turn_q1", 32'(q_a), SAT ? 1 : 9);
    tick();
    chk("turn_q2", 32'(q_a), SAT ? 2 : 0);
    chk("turn_wrap", 32'(wr_a), SAT ? 0 : 1);

    // load beats enable; oversize data clamps
    load = 1'b1; data = 4'd4;
    tick();
    chk("load_prio", 32'(q_a), 4);
    chk("load_wrap", 32'(wr_a), 0);
    data = 4'd13;
    tick();
    chk("load_clamp", 32'(q_a), 9);
    load = 1'b0; en_a = 1'b0; data = 4'd0;

    // two-digit decimal cascade
    do_clear();
    en_c = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (k == 37) begin
        chk("casc37_lo", 32'(q_lo), SAT ? 9 : 7);
        chk("casc37_hi", 32'(q_hi), SAT ? 9 : 3);
      end
    end
    chk("casc100_lo", 32'(q_lo), SAT ? 9 : 0);
    chk("casc100_hi", 32'(q_hi), SAT ? 9 : 0);
    en_c = 1'b0;

    // full-width 8-bit counter
    do_clear();
    en_b = 1'b1;
    nwraps = 0;
    repeat (256) begin
      tick();
      if (wr_b) nwraps++;
    end
    chk("full_q", 32'(q_b), SAT ? 255 : 0);
    chk("full_wraps", nwraps, SAT ? 0 : 1);
    en_b = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
